// File: rtl/poly_wavetable_engine.sv
// Polyphonic wavetable engine: NUM_VOICES phase-accumulator voices with
// linear attack/release envelopes, swept once per codec sample through a
// shared external waveform ROM and mixed with saturation to 16-bit signed.
module poly_wavetable_engine #(
   parameter int NUM_VOICES   = 4,
   parameter int PHASE_W      = 24,
   parameter int ADDR_W       = 8,
   parameter int KEY_W        = 4,
   parameter int ATTACK_STEP  = 16,
   parameter int RELEASE_STEP = 4
) (
   input  logic                  clk_50,
   input  logic                  ar,
   input  logic                  sample_tick,
   input  logic                  note_valid,
   output logic                  note_ready,
   input  logic                  note_on,
   input  logic [KEY_W-1:0]      note_key,
   input  logic [PHASE_W-1:0]    note_inc,
   input  logic [1:0]            note_wave,
   output logic [ADDR_W+1:0]     rom_addr,
   input  logic [15:0]           rom_data,
   output logic [15:0]           sample_out,
   output logic                  sample_valid,
   output logic [NUM_VOICES-1:0] voice_active,
   output logic                  overrun
);

   localparam int VIDX_W = $clog2(NUM_VOICES);
   localparam int ACC_W  = 16 + VIDX_W;
   localparam logic [8:0] ATK9 = 9'(ATTACK_STEP);
   localparam logic [7:0] REL8 = 8'(RELEASE_STEP);

   typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_FLUSH, ST_OUT} top_state_t;
   typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} voice_state_t;

   top_state_t state, state_next;

   voice_state_t       v_state [NUM_VOICES];
   logic [PHASE_W-1:0] v_phase [NUM_VOICES];
   logic [PHASE_W-1:0] v_inc   [NUM_VOICES];
   logic [7:0]         v_env   [NUM_VOICES];
   logic [1:0]         v_wave  [NUM_VOICES];
   logic [KEY_W-1:0]   v_key   [NUM_VOICES];

   logic [VIDX_W-1:0] slot;
   logic [VIDX_W-1:0] steal_ptr;

   logic                  note_fire;
   logic                  match_hit, free_hit;
   logic [VIDX_W-1:0]     match_idx, free_idx, alloc_idx;
   logic [NUM_VOICES-1:0] off_mask;

   voice_state_t cur_state;
   logic [7:0]   cur_env;
   logic [8:0]   env_up;

   logic               mix_valid;
   logic [7:0]         mix_env;
   logic signed [23:0] mix_prod;
   logic [15:0]        term;
   logic [ACC_W-1:0]   acc, acc_sum;
   logic [ACC_W-16:0]  sat_hi;
   logic [15:0]        sat_val;

   // Top sequencer state register; reset aborts any sweep in progress.
   always_ff @(posedge clk_50) begin
      if (ar) state <= ST_IDLE;
      else    state <= state_next;
   end

   // Sequencer next state: a tick starts a sweep, one slot per voice, then flush and output.
   always_comb begin
      state_next = state;
      note_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            note_ready = ~ar;
            if (sample_tick) state_next = ST_SWEEP;
         end
         ST_SWEEP: begin
            if (slot == VIDX_W'(NUM_VOICES - 1)) state_next = ST_FLUSH;
         end
         ST_FLUSH: state_next = ST_OUT;
         ST_OUT:   state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Voice slot counter: cleared when a sweep starts, advanced once per sweep cycle.
   always_ff @(posedge clk_50) begin
      if (ar) slot <= '0;
      else if (state == ST_IDLE && sample_tick) slot <= '0;
      else if (state == ST_SWEEP) slot <= slot + VIDX_W'(1);
   end

   // ROM address for the voice occupying the current slot.
   always_comb begin
      rom_addr = {v_wave[slot], v_phase[slot][PHASE_W-1 -: ADDR_W]};
   end

   // Note allocation search: lowest-index key match, lowest-index free voice, note-off mask.
   always_comb begin
      note_fire = note_valid & note_ready;
      match_hit = 1'b0;
      match_idx = '0;
      free_hit  = 1'b0;
      free_idx  = '0;
      off_mask  = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (v_state[i] != V_IDLE && v_key[i] == note_key) begin
            match_hit   = 1'b1;
            match_idx   = VIDX_W'(i);
            off_mask[i] = 1'b1;
         end
         if (v_state[i] == V_IDLE) begin
            free_hit = 1'b1;
            free_idx = VIDX_W'(i);
         end
      end
      if (match_hit)     alloc_idx = match_idx;
      else if (free_hit) alloc_idx = free_idx;
      else               alloc_idx = steal_ptr;
   end

   // Envelope arithmetic for the voice in the current slot.
   always_comb begin
      cur_state = v_state[slot];
      cur_env   = v_env[slot];
      env_up    = {1'b0, cur_env} + ATK9;
   end

   // Voice registers: note events in IDLE, phase/envelope advance during each voice's sweep slot.
   always_ff @(posedge clk_50) begin
      if (ar) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            v_state[i] <= V_IDLE;
            v_phase[i] <= '0;
            v_inc[i]   <= '0;
            v_env[i]   <= '0;
            v_wave[i]  <= '0;
            v_key[i]   <= '0;
         end
         steal_ptr <= '0;
      end else begin
         if (note_fire) begin
            if (note_on) begin
               v_state[alloc_idx] <= V_ATTACK;
               v_inc[alloc_idx]   <= note_inc;
               v_wave[alloc_idx]  <= note_wave;
               v_key[alloc_idx]   <= note_key;
               if (!match_hit) begin
                  v_phase[alloc_idx] <= '0;
                  v_env[alloc_idx]   <= '0;
               end
               if (!match_hit && !free_hit) begin
                  if (steal_ptr == VIDX_W'(NUM_VOICES - 1)) steal_ptr <= '0;
                  else                                      steal_ptr <= steal_ptr + VIDX_W'(1);
               end
            end else begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (off_mask[i]) v_state[i] <= V_RELEASE;
               end
            end
         end
         if (state == ST_SWEEP) begin
            if (cur_state != V_IDLE) v_phase[slot] <= v_phase[slot] + v_inc[slot];
            case (cur_state)
               V_ATTACK: begin
                  if (env_up >= 9'd255) begin
                     v_env[slot]   <= 8'd255;
                     v_state[slot] <= V_SUSTAIN;
                  end else begin
                     v_env[slot] <= env_up[7:0];
                  end
               end
               V_RELEASE: begin
                  if (cur_env <= REL8) begin
                     v_env[slot]   <= 8'd0;
                     v_state[slot] <= V_IDLE;
                  end else begin
                     v_env[slot] <= cur_env - REL8;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Scaled ROM term, running sum and 16-bit saturation of the sum.
   always_comb begin
      mix_prod = $signed({{8{rom_data[15]}}, rom_data}) * $signed({16'd0, mix_env});
      term     = 16'(mix_prod >>> 8);
      acc_sum  = acc + {{(ACC_W-16){term[15]}}, term};
      sat_hi   = acc_sum[ACC_W-1:15];
      if (&sat_hi || ~|sat_hi) sat_val = acc_sum[15:0];
      else if (acc_sum[ACC_W-1]) sat_val = 16'h8000;
      else sat_val = 16'h7FFF;
   end

   // Mix pipeline: latch the pre-update envelope at address issue, accumulate when data returns.
   always_ff @(posedge clk_50) begin
      if (ar) begin
         mix_valid    <= 1'b0;
         mix_env      <= '0;
         acc          <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         mix_valid    <= (state == ST_SWEEP);
         mix_env      <= (cur_state != V_IDLE) ? cur_env : 8'd0;
         sample_valid <= (state == ST_FLUSH);
         if (state == ST_IDLE && sample_tick) acc <= '0;
         else if (mix_valid)                  acc <= acc_sum;
         if (state == ST_FLUSH) sample_out <= sat_val;
         if (sample_tick && state != ST_IDLE) overrun <= 1'b1;
      end
   end

   // Registered view of which voices are sounding.
   always_ff @(posedge clk_50) begin
      if (ar) begin
         voice_active <= '0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) voice_active[i] <= (v_state[i] != V_IDLE);
      end
   end

endmodule

// File: tb/tb_poly_wavetable_engine.sv
// Directed self-checking bench for poly_wavetable_engine with default parameters
// and a constant-valued registered ROM model.
module tb_poly_wavetable_engine;

   logic        clk_50 = 1'b0;
   logic        ar = 1'b1;
   logic        sample_tick = 1'b0;
   logic        note_valid = 1'b0;
   logic        note_ready;
   logic        note_on = 1'b0;
   logic [3:0]  note_key = '0;
   logic [23:0] note_inc = '0;
   logic [1:0]  note_wave = '0;
   logic [9:0]  rom_addr;
   logic [15:0] rom_data = '0;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic [3:0]  voice_active;
   logic        overrun;

   logic [15:0] rom_val = 16'h0000;
   logic [9:0]  cap_addr [4];
   int          n_compared = 0;
   int          n_mismatched = 0;

   poly_wavetable_engine dut (
      .clk_50       (clk_50),
      .ar           (ar),
      .sample_tick  (sample_tick),
      .note_valid   (note_valid),
      .note_ready   (note_ready),
      .note_on      (note_on),
      .note_key     (note_key),
      .note_inc     (note_inc),
      .note_wave    (note_wave),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .voice_active (voice_active),
      .overrun      (overrun)
   );

   // 50 MHz-style free-running clock.
   always #5 clk_50 = ~clk_50;

   // Registered ROM model: data follows the address by one cycle.
   always @(posedge clk_50) rom_data <= rom_val;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_note(input logic on, input logic [3:0] key, input logic [23:0] inc, input logic [1:0] wave);
      @(negedge clk_50);
      check_output("note_ready_before_note", note_ready, 1'b1);
      note_valid = 1'b1;
      note_on    = on;
      note_key   = key;
      note_inc   = inc;
      note_wave  = wave;
      @(negedge clk_50);
      note_valid = 1'b0;
   endtask

   task automatic run_sample(output logic [15:0] val, output int lat);
      @(negedge clk_50);
      sample_tick = 1'b1;
      @(negedge clk_50);
      sample_tick = 1'b0;
      lat = 1;
      cap_addr[0] = rom_addr;
      while (sample_valid !== 1'b1 && lat < 40) begin
         @(negedge clk_50);
         lat++;
         if (lat <= 4) cap_addr[lat-1] = rom_addr;
      end
      val = sample_out;
      @(negedge clk_50);
      check_output("valid_one_cycle", sample_valid, 1'b0);
   endtask

   task automatic count_valid(input int cycles, output int pulses);
      pulses = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk_50);
         if (sample_valid === 1'b1) pulses++;
      end
   endtask

   // Directed sequence covering reset, attack, release, allocation, saturation, overrun and mid-sweep reset.
   initial begin
      logic [15:0] val;
      int          lat;
      int          pulses;
      logic [15:0] exp_val;

      // Reset behaviour.
      repeat (3) @(negedge clk_50);
      check_output("rst_note_ready", note_ready, 1'b0);
      check_output("rst_sample_out", sample_out, 16'h0000);
      check_output("rst_sample_valid", sample_valid, 1'b0);
      check_output("rst_voice_active", voice_active, 4'h0);
      check_output("rst_overrun", overrun, 1'b0);
      ar = 1'b0;
      @(negedge clk_50);
      check_output("post_rst_note_ready", note_ready, 1'b1);
      count_valid(20, pulses);
      check_output("idle_no_valid", pulses, 0);
      check_output("idle_sample_out", sample_out, 16'h0000);
      check_output("idle_voice_active", voice_active, 4'h0);

      // Attack ramp then sustain on a single voice.
      $display("[TB] attack ramp");
      rom_val = 16'h1000;
      apply_note(1'b1, 4'd3, 24'h010000, 2'd0);
      for (int k = 0; k < 18; k++) begin
         run_sample(val, lat);
         exp_val = (k < 16) ? 16'(k * 256) : 16'h0FF0;
         check_output($sformatf("attack_lat_%0d", k), lat, 6);
         check_output($sformatf("attack_val_%0d", k), val, exp_val);
         check_output($sformatf("attack_phase_%0d", k), cap_addr[0], {2'b00, 8'(k)});
         if (k == 0) check_output("attack_voice_active", voice_active, 4'b0001);
         repeat (10) @(negedge clk_50);
      end

      // Release down to silence.
      $display("[TB] release");
      apply_note(1'b0, 4'd3, 24'h0, 2'd0);
      for (int j = 0; j < 65; j++) begin
         run_sample(val, lat);
         exp_val = (j <= 63) ? 16'((255 - 4 * j) * 16) : 16'h0000;
         check_output($sformatf("release_val_%0d", j), val, exp_val);
         if (j == 0)  check_output("release_lat", lat, 6);
         if (j == 62) check_output("release_still_active", voice_active, 4'b0001);
      end
      check_output("release_voice_idle", voice_active, 4'b0000);

      // Allocation, stealing, ignored note-off, retrigger.
      $display("[TB] allocation");
      apply_note(1'b1, 4'd1, 24'h010000, 2'd1);
      apply_note(1'b1, 4'd2, 24'h010000, 2'd2);
      apply_note(1'b1, 4'd3, 24'h010000, 2'd3);
      apply_note(1'b1, 4'd4, 24'h010000, 2'd1);
      apply_note(1'b1, 4'd5, 24'h010000, 2'd0);
      apply_note(1'b0, 4'd1, 24'h0, 2'd0);
      run_sample(val, lat);
      check_output("alloc_addr_v0", cap_addr[0], 10'h000);
      check_output("alloc_addr_v1", cap_addr[1], 10'h200);
      check_output("alloc_addr_v2", cap_addr[2], 10'h300);
      check_output("alloc_addr_v3", cap_addr[3], 10'h100);
      check_output("alloc_val", val, 16'h0000);
      check_output("alloc_noteoff_ignored", voice_active, 4'b1111);
      apply_note(1'b1, 4'd6, 24'h010000, 2'd3);
      run_sample(val, lat);
      check_output("steal2_addr_v0", cap_addr[0], 10'h001);
      check_output("steal2_addr_v1", cap_addr[1], 10'h300);
      check_output("steal2_addr_v2", cap_addr[2], 10'h301);
      check_output("steal2_addr_v3", cap_addr[3], 10'h101);
      check_output("steal2_val", val, 16'h0300);
      apply_note(1'b1, 4'd3, 24'h010000, 2'd0);
      run_sample(val, lat);
      check_output("retrig_addr_v0", cap_addr[0], 10'h002);
      check_output("retrig_addr_v1", cap_addr[1], 10'h301);
      check_output("retrig_addr_v2", cap_addr[2], 10'h002);
      check_output("retrig_addr_v3", cap_addr[3], 10'h102);
      check_output("retrig_val", val, 16'h0700);

      // Mixing and saturation with all four voices in sustain.
      $display("[TB] saturation");
      repeat (18) run_sample(val, lat);
      rom_val = 16'h0100;
      run_sample(val, lat);
      check_output("mix_pos_small", val, 16'h03FC);
      rom_val = 16'hFF00;
      run_sample(val, lat);
      check_output("mix_neg_small", val, 16'hFC04);
      rom_val = 16'h2000;
      run_sample(val, lat);
      check_output("mix_pos_edge", val, 16'h7F80);
      rom_val = 16'hE000;
      run_sample(val, lat);
      check_output("mix_neg_edge", val, 16'h8080);
      rom_val = 16'h7FFF;
      run_sample(val, lat);
      check_output("sat_pos", val, 16'h7FFF);
      rom_val = 16'h8000;
      run_sample(val, lat);
      check_output("sat_neg", val, 16'h8000);

      // Overrun: a second tick two cycles into the sweep.
      $display("[TB] overrun");
      check_output("overrun_clear", overrun, 1'b0);
      @(negedge clk_50);
      sample_tick = 1'b1;
      @(negedge clk_50);
      sample_tick = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 20; c++) begin
         sample_tick = (c == 2);
         if (sample_valid === 1'b1) begin
            pulses++;
            val = sample_out;
         end
         @(negedge clk_50);
      end
      sample_tick = 1'b0;
      check_output("overrun_one_valid", pulses, 1);
      check_output("overrun_val", val, 16'h8000);
      check_output("overrun_set", overrun, 1'b1);
      run_sample(val, lat);
      check_output("overrun_sticky", overrun, 1'b1);
      check_output("overrun_next_lat", lat, 6);

      // Reset in the middle of a sweep.
      $display("[TB] mid-sweep reset");
      @(negedge clk_50);
      sample_tick = 1'b1;
      @(negedge clk_50);
      sample_tick = 1'b0;
      @(negedge clk_50);
      ar = 1'b1;
      @(negedge clk_50);
      check_output("midrst_note_ready", note_ready, 1'b0);
      ar = 1'b0;
      count_valid(20, pulses);
      check_output("midrst_no_valid", pulses, 0);
      check_output("midrst_sample_out", sample_out, 16'h0000);
      check_output("midrst_overrun", overrun, 1'b0);
      check_output("midrst_voice_active", voice_active, 4'h0);
      check_output("midrst_note_ready_after", note_ready, 1'b1);
      run_sample(val, lat);
      check_output("midrst_lat", lat, 6);
      check_output("midrst_val", val, 16'h0000);
      check_output("midrst_addr", cap_addr[0], 10'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
